// File: rtl/binary_counter_n.sv
// binary_counter_n
// Up/down modulo-N counter with parallel load, synchronous clear, a
// combinational terminal-count carry/borrow for cascading, and a sticky
// over/underflow flag. Terminal behaviour is either wrap or saturate.
module binary_counter_n #(
    parameter int unsigned WIDTH    = 8,
    parameter logic [32:0] MODULUS  = 33'd1 << WIDTH,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf
);

    // Terminal value, kept in WIDTH+1 bits so it can be compared against
    // guard-extended sums without truncation.
    localparam logic [32:0]      MOD_M1  = MODULUS - 33'd1;
    localparam logic [WIDTH:0]   MAX_EXT = MOD_M1[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_VAL = MOD_M1[WIDTH-1:0];
    localparam logic [WIDTH:0]   ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    // Elaboration-time legality checks on the parameter set.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("binary_counter_n: WIDTH must be within 2..32");
    end
    if (MODULUS < 33'd2 || MODULUS > (33'd1 << WIDTH)) begin : g_bad_modulus
        $error("binary_counter_n: MODULUS must be within 2..2**WIDTH");
    end

    // Operation selected for the coming edge, in priority order.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_COUNT,
        OP_LOAD,
        OP_INIT
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   din_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic             up_terminal;
    logic             down_terminal;
    logic             din_over;

    // Guard-bit arithmetic: an increment past MAX shows up as inc_ext > MAX,
    // a decrement below zero shows up as a borrow into the guard bit.
    always_comb begin
        count_ext     = {1'b0, count_q};
        din_ext       = {1'b0, din};
        inc_ext       = count_ext + ONE_EXT;
        dec_ext       = count_ext - ONE_EXT;
        up_terminal   = (inc_ext > MAX_EXT);
        down_terminal = dec_ext[WIDTH];
        din_over      = (din_ext > MAX_EXT);
    end

    // Priority decode: init beats load beats count beats hold.
    always_comb begin
        op = OP_HOLD;
        if (init) begin
            op = OP_INIT;
        end else if (load) begin
            op = OP_LOAD;
        end else if (cin) begin
            op = OP_COUNT;
        end
    end

    // Next count and next flag for the selected operation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; a missed branch would otherwise infer a latch.
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (op)
            OP_INIT: begin
                count_d = '0;
                ovf_d   = 1'b0;
            end
            OP_LOAD: begin
                if (din_over) begin
                    count_d = MAX_VAL;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = din;
                end
            end
            OP_COUNT: begin
                if (up) begin
                    if (up_terminal) begin
                        count_d = SAT_MODE ? MAX_VAL : '0;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = inc_ext[WIDTH-1:0];
                    end
                end else begin
                    if (down_terminal) begin
                        count_d = SAT_MODE ? '0 : MAX_VAL;
                        ovf_d   = 1'b1;
                    end else begin
                        count_d = dec_ext[WIDTH-1:0];
                    end
                end
            end
            default: begin
                count_d = count_q;
                ovf_d   = ovf_q;
            end
        endcase
    end

    // State registers; reset clears count and flag without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Terminal-count carry/borrow is purely combinational and deliberately
    // not qualified by init or load; the next stage decides what to do.
    always_comb begin
        cout = cin & ((up & up_terminal) | (~up & down_terminal));
    end

    assign q   = count_q;
    assign ovf = ovf_q;

endmodule

// File: doc/binary_counter_n.md
BINARY_COUNTER_N -- requirements
Module: binary_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (legal 2..2**WIDTH); MAX = MODULUS-1.
REQ-003 SHALL have parameter SAT_MODE, default 0; 0 = wrap at terminal, 1 = saturate at terminal.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port init  input  1  synchronous clear of count and flag.
REQ-007 SHALL have port load  input  1  synchronous parallel load of din.
REQ-008 SHALL have port din  input  WIDTH  parallel load value.
REQ-009 SHALL have port cin  input  1  count enable / carry-in from a lower stage.
REQ-010 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-011 SHALL have port q  output  WIDTH  registered count value.
REQ-012 SHALL have port cout  output  1  combinational terminal-count carry/borrow for cascading.
REQ-013 SHALL have port ovf  output  1  registered sticky over/underflow flag.

Function
REQ-014 SHALL apply per-edge priority: rst low > init > load > cin count > hold.
REQ-015 SHALL, on init=1, set q=0 and ovf=0 at the next rising edge regardless of load/cin.
REQ-016 SHALL, on load=1 (init=0), set q=din when din<=MAX; when din>MAX, set q=MAX and ovf=1.
REQ-017 SHALL, on load=1 with din<=MAX, leave ovf unchanged.
REQ-018 SHALL, on cin=1, up=1, q<MAX, set q=q+1 next edge.
REQ-019 SHALL, on cin=1, up=0, q>0, set q=q-1 next edge.
REQ-020 SHALL, on cin=1, up=1, q==MAX: q=0 if SAT_MODE=0, q holds MAX if SAT_MODE=1; ovf=1 in both modes.
REQ-021 SHALL, on cin=1, up=0, q==0: q=MAX if SAT_MODE=0, q holds 0 if SAT_MODE=1; ovf=1 in both modes.
REQ-022 SHALL hold q and ovf when init=load=cin=0.
REQ-023 SHALL drive cout = cin & ((up & q==MAX) | (~up & q==0)), no register stage, same cycle as inputs.
REQ-024 SHALL NOT gate cout with init or load; cascading logic owns that qualification.
REQ-025 SHALL keep ovf set once set until rst, init, or cleared per REQ-015.
REQ-026 SHALL compute all arithmetic in WIDTH bits plus one guard bit; q never holds a value >MAX.
REQ-027 SHALL allow direction change on any cycle; new direction applies at that edge with zero latency.
REQ-028 SHALL use a single clock domain with no internal clock gating.

Reset
REQ-029 SHALL, while rst=0, force q=0 and ovf=0 immediately, independent of clk.
REQ-030 SHALL, while rst=0, output cout per REQ-023 using q=0.
REQ-031 SHALL resume counting on the first rising edge after rst deasserts; reset mid-count discards the count.

Verification
REQ-032 SHALL verify: WIDTH=8 default, rst low 15 ns, then cin=1, up=1 for 256 edges -> q runs 0..255, wraps to 0 on edge 256, cout=1 only while q=255, ovf=1 after wrap.
REQ-033 SHALL verify: MODULUS=10, SAT_MODE=0, up=0 from q=0 with cin=1 -> q=9 next edge, ovf=1, cout=1 in cycle with q=0.
REQ-034 SHALL verify: SAT_MODE=1, WIDTH=8, load din=8'hFE then cin=1, up=1 for 3 edges -> q=FF, FF, FF; ovf=1 after third edge.
REQ-035 SHALL verify: MODULUS=10, load din=12 -> q=9, ovf=1; next init=1 with load=1, cin=1 -> q=0, ovf=0.
REQ-036 SHALL verify: rst pulsed low asynchronously between edges at q=0x37 -> q=0, ovf=0 before next edge; counting resumes from 0 after release.
REQ-037 SHALL verify: two instances cascaded (low cout -> high cin), WIDTH=4, 20 enabled edges -> combined value 0x14 with high stage stepping only on low-stage terminal.
